dbus_responder: RTL
===================

Name: dbus_responder

Overview:
- Data-bus responder (target side) for the CPU execute stage's data request interface.
- Accepts one-cycle load/store requests into a small in-order request FIFO and services them against a local word-organised data RAM with configurable wait states.
- Returns one response pulse per accepted request, in order: read data, write acknowledge, or error.
- Sits between the CPU data port and on-chip data memory.

Parameters:
ADDR_WIDTH, 14, word-address bits; RAM holds 2**ADDR_WIDTH 32-bit words.
WAIT_STATES, 1, extra access cycles per request (0..15).
FIFO_DEPTH, 4, request FIFO entries (power of two, >=2).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
cpu_request  in  1  one-cycle request strobe.
cpu_addr  in  32  byte address.
cpu_write  in  1  1 = store, 0 = load.
cpu_byte_enable  in  4  store byte lanes.
cpu_wdata  in  32  lane-aligned store data.
cpu_size  in  2  00 = byte, 01 = halfword, 10 = word.
cpu_busy  out  1  FIFO count >= FIFO_DEPTH-1; CPU must stall new requests.
cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid.
cpu_rdata  out  32  load data, right-justified, zero-extended.
cpu_wack  out  1  one-cycle pulse; store completed.
cpu_error  out  1  one-cycle pulse; request rejected.
overflow  out  1  sticky; a request arrived while the FIFO was full.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO emptied; FSM to IDLE; wait counter cleared.
  - cpu_rvalid, cpu_wack, cpu_error and overflow cleared; cpu_rdata = 0.
  - cpu_busy follows the count, so it reads 0.
  - RAM contents are not cleared. In-flight or queued requests are discarded, with no response.
- Push: on each edge with cpu_request = 1, {addr, write, byte_enable, wdata, size} is written to the FIFO tail if count < FIFO_DEPTH.
  - If count == FIFO_DEPTH, the request is dropped and overflow is set.
  - A simultaneous push and pop leaves count unchanged; a push is accepted at full if a pop occurs on the same edge.
- FSM:
  - IDLE: if FIFO is non-empty, pop head into working registers, load wait counter = WAIT_STATES, go to ACCESS.
  - ACCESS: if counter != 0, decrement. If counter == 0, complete the access (below). Then, if FIFO is non-empty, pop the next entry and stay in ACCESS with counter reloaded; else go to IDLE.
- Completion (at the completing edge; response outputs are registered, visible the next cycle for exactly one cycle):
  - Error check, any one of:
    - addr[31:ADDR_WIDTH+2] != 0;
    - size == 11;
    - size == 01 and addr[0];
    - size == 10 and addr[1:0] != 0;
    - write with byte_enable == 0.
  - Error: cpu_error = 1, cpu_rdata = 0, RAM untouched.
  - Store: RAM[addr[ADDR_WIDTH+1:2]] lanes selected by byte_enable take the matching wdata lanes; cpu_wack = 1.
  - Load: the word is read, shifted right by 8*addr[1:0], then masked to 8/16/32 bits per size, upper bits zero; cpu_rvalid = 1.
  - cpu_rvalid, cpu_wack and cpu_error are mutually exclusive. cpu_rdata holds its last value when cpu_rvalid = 0.
- Latency and throughput:
  - Request in cycle 0 gives its response visible in cycle 3 + WAIT_STATES.
  - Back-to-back queued requests respond every WAIT_STATES+1 cycles.
  - Responses are strictly in request order.
- Load after store to the same address returns the stored data; ordering is guaranteed by the FIFO.

Test Plan:
- WAIT_STATES=0: STW 0x100 BE 1111 wdata 0x12345678 in cycle 0, LDW 0x100 in cycle 1 -> cpu_wack in cycle 3; cpu_rvalid in cycle 4 with cpu_rdata = 0x12345678.
- STB 0x103 BE 1000 wdata 0xAB000000, then LDBU 0x103 -> rdata 0x000000AB; then LDW 0x100 -> 0xAB345678; then LDH 0x102 -> 0x0000AB34.
- WAIT_STATES=2: four LDW requests on consecutive cycles -> four in-order cpu_rvalid pulses, 3 cycles apart, first in cycle 5; cpu_busy high while count >= 3.
- Errors:
  - LDW 0x102 -> cpu_error pulse, no rvalid.
  - STW 0x00010000 (ADDR_WIDTH=14) -> cpu_error; subsequent LDW 0x0 returns the unchanged value.
  - size=11 -> cpu_error.
- Overflow: WAIT_STATES=3, FIFO_DEPTH=4, seven requests on consecutive cycles ignoring cpu_busy -> 7th dropped, overflow = 1 and stays 1, exactly six responses.
- Assert reset low while in ACCESS with 2 entries queued -> all outputs 0 immediately, no responses afterwards; a LDW after release returns previously written RAM data.

Source files
------------

// File: rtl/dbus_if.sv
// Data-bus interface between the CPU execute stage (master) and the data responder (slave).
interface dbus_if;
  logic        cpu_request;
  logic [31:0] cpu_addr;
  logic        cpu_write;
  logic [3:0]  cpu_byte_enable;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_size;
  logic        cpu_busy;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_wack;
  logic        cpu_error;
  logic        overflow;

  modport master (
    output cpu_request, cpu_addr, cpu_write, cpu_byte_enable, cpu_wdata, cpu_size,
    input  cpu_busy, cpu_rvalid, cpu_rdata, cpu_wack, cpu_error, overflow
  );

  modport slave (
    input  cpu_request, cpu_addr, cpu_write, cpu_byte_enable, cpu_wdata, cpu_size,
    output cpu_busy, cpu_rvalid, cpu_rdata, cpu_wack, cpu_error, overflow
  );
endinterface

// File: rtl/dbus_responder.sv
// Data-bus responder: queues CPU load/store requests in an in-order FIFO and
// services them against a local word RAM with a fixed number of wait states.
module dbus_responder #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic   clock,
  input  logic   reset,
  dbus_if.slave  bus
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned WAIT_W    = 4;
  localparam int unsigned RAM_WORDS = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  size;
  } req_t;

  typedef enum logic [0:0] {ST_IDLE, ST_ACCESS} state_t;

  state_t                  state;
  logic [WAIT_W-1:0]       wait_cnt;
  req_t                    work;
  req_t                    in_req;
  req_t                    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic [31:0]             mem [RAM_WORDS];

  logic                    busy_q;
  logic                    overflow_q;
  logic                    rvalid_q;
  logic                    wack_q;
  logic                    error_q;
  logic [31:0]             rdata_q;

  logic                    full_c;
  logic                    access_done_c;
  logic                    pop_c;
  logic                    push_c;
  logic                    err_c;
  logic                    ram_we_c;
  logic [ADDR_WIDTH-1:0]   widx_c;
  logic [31:0]             shifted_c;
  logic [31:0]             load_c;

  assign in_req = '{addr:  bus.cpu_addr,
                    write: bus.cpu_write,
                    be:    bus.cpu_byte_enable,
                    wdata: bus.cpu_wdata,
                    size:  bus.cpu_size};

  // FIFO control, access decode and load data formatting.
  always_comb begin
    full_c        = (count == CNT_W'(FIFO_DEPTH));
    access_done_c = (state == ST_ACCESS) && (wait_cnt == '0);
    pop_c         = (count != '0) && ((state == ST_IDLE) || access_done_c);
    push_c        = bus.cpu_request && (!full_c || pop_c);
    count_next    = count + CNT_W'(push_c) - CNT_W'(pop_c);

    err_c = ((work.addr >> (ADDR_WIDTH + 2)) != 32'd0)
         || (work.size == 2'b11)
         || ((work.size == 2'b01) && work.addr[0])
         || ((work.size == 2'b10) && (work.addr[1:0] != 2'b00))
         || (work.write && (work.be == 4'b0000));

    ram_we_c  = access_done_c && work.write && !err_c;
    widx_c    = work.addr[ADDR_WIDTH+1:2];
    shifted_c = mem[widx_c] >> {work.addr[1:0], 3'b000};
    case (work.size)
      2'b00:   load_c = {24'd0, shifted_c[7:0]};
      2'b01:   load_c = {16'd0, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase
  end

  // FIFO pointers, occupancy, busy and sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_next;
      busy_q     <= (count_next >= CNT_W'(FIFO_DEPTH - 1));
      overflow_q <= overflow_q | (bus.cpu_request & full_c & ~pop_c);
    end
  end

  // FIFO storage; payload needs no reset since occupancy is tracked separately.
  always_ff @(posedge clock) begin
    if (push_c) fifo_mem[wr_ptr] <= in_req;
  end

  // Data RAM byte-lane writes; contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (work.be[i]) mem[widx_c][8*i +: 8] <= work.wdata[8*i +: 8];
      end
    end
  end

  // Access FSM with registered one-cycle response pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      work     <= '0;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      error_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      error_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop_c) begin
            work     <= fifo_mem[rd_ptr];
            wait_cnt <= WAIT_W'(WAIT_STATES);
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else begin
            if (err_c) begin
              error_q <= 1'b1;
              rdata_q <= '0;
            end else if (work.write) begin
              wack_q <= 1'b1;
            end else begin
              rvalid_q <= 1'b1;
              rdata_q  <= load_c;
            end
            if (pop_c) begin
              work     <= fifo_mem[rd_ptr];
              wait_cnt <= WAIT_W'(WAIT_STATES);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_busy   = busy_q;
  assign bus.overflow   = overflow_q;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.cpu_wack   = wack_q;
  assign bus.cpu_error  = error_q;
  assign bus.cpu_rdata  = rdata_q;

endmodule
